// File: rtl/vmode_sched.sv
// Frame-synchronous commit of vertical sync mode configuration (mono/ntsc/interlace)
// with interlace field tracking and a line-count watchdog. Optional: VMODE_FRAMECNT_EN.
module vmode_sched #(
  parameter int TIMEOUT_LINES = 600,
  parameter int CNT_W         = 10
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       vertclk_en,
  input  logic       iivsync,
  input  logic       cfg_we,
  input  logic [1:0] cfg_res,
  input  logic       cfg_ntsc,
  input  logic       cfg_ilace,
  output logic       mde1,
  output logic       mde1b,
  output logic       ntsc,
  output logic       interlace,
  output logic       field,
  output logic       busy,
  output logic       vs_start,
`ifdef VMODE_FRAMECNT_EN
  output logic [15:0] frame_cnt,
  output logic        commit_pulse,
`endif
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_LINES - 1);

  state_t           state_reg, state_next;
  logic [2:0]       pend_reg, pend_next;   // {mono, ntsc, interlace}
  logic [2:0]       mode_reg, mode_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             field_reg, field_next;
  logic             timeout_reg, timeout_next;
  logic             vs_q_reg, vs_start_reg;
  logic             vs_fall;
  logic             res_mono;
  logic [2:0]       cfg_word;

  // Reserved resolution 3 decodes as mono.
  assign res_mono = (cfg_res == 2'd2) || (cfg_res == 2'd3);
  assign cfg_word = {res_mono, cfg_ntsc, cfg_ilace};
  assign vs_fall  = vs_q_reg & ~iivsync;

  always_comb begin
    state_next   = state_reg;
    pend_next    = pend_reg;
    mode_next    = mode_reg;
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      IDLE: begin
        if (cfg_we) begin
          pend_next    = cfg_word;
          timeout_next = 1'b0;
          cnt_next     = '0;
          state_next   = PENDING;
        end
      end
      PENDING: begin
        if (cfg_we) begin
          pend_next    = cfg_word;
          timeout_next = 1'b0;
          cnt_next     = '0;
        end
        if (vs_fall) begin
          state_next = COMMIT;
        end else if (vertclk_en && !cfg_we) begin
          if (cnt_reg == CNT_LAST) begin
            timeout_next = 1'b1;
            state_next   = COMMIT;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      COMMIT: begin
        mode_next  = pend_reg;
        state_next = IDLE;
        // A write landing on the commit cycle queues for the next frame.
        if (cfg_we) begin
          pend_next    = cfg_word;
          timeout_next = 1'b0;
          cnt_next     = '0;
          state_next   = PENDING;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    field_next = field_reg;
    if (vs_fall) begin
      field_next = mode_reg[0] ? ~field_reg : 1'b0;
    end
    if (state_reg == COMMIT && !pend_reg[0]) begin
      field_next = 1'b0;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_reg    <= IDLE;
      pend_reg     <= '0;
      cnt_reg      <= '0;
      field_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
      vs_q_reg     <= 1'b1;
      vs_start_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pend_reg     <= pend_next;
      cnt_reg      <= cnt_next;
      field_reg    <= field_next;
      timeout_reg  <= timeout_next;
      vs_q_reg     <= iivsync;
      vs_start_reg <= vs_fall;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_mode
      always_ff @(posedge clk32) begin
        if (reset) begin
          mode_reg[gi] <= 1'b0;
        end else begin
          mode_reg[gi] <= mode_next[gi];
        end
      end
    end
  endgenerate

`ifdef VMODE_FRAMECNT_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk32) begin
    if (reset) begin
      frame_cnt_reg <= '0;
    end else if (vs_fall) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt    = frame_cnt_reg;
  assign commit_pulse = (state_reg == COMMIT);
`endif

  assign mde1      = mode_reg[2];
  assign mde1b     = ~mode_reg[2];
  assign ntsc      = mode_reg[1];
  assign interlace = mode_reg[0];
  assign field     = field_reg;
  assign busy      = (state_reg != IDLE);
  assign vs_start  = vs_start_reg;
  assign timeout   = timeout_reg;

endmodule

// File: doc/vmode_sched.md
Name: vmode_sched

Overview:
- Frame-synchronous scheduler for the GSTMCU vertical sync generator's configuration inputs: mde1/mde1b (mono), ntsc and interlace.
- CPU writes to the resolution and sync-mode registers are held as pending. They are committed only at the start of vertical sync, so the vertical counter never sees a mode change mid-frame.
- Also tracks the interlace field.
- Includes a line-count watchdog that commits the pending config if vsync never arrives, e.g. when the counter is stalled or misconfigured.

Parameters:
- TIMEOUT_LINES, 600: vertclk_en pulses in PENDING without a vsync before a forced commit. Must be ≥ 2 and exceed 525.
- CNT_W, 10: width of the watchdog line counter. Must hold TIMEOUT_LINES.

Ports:
- clk32  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- vertclk_en  input  1  one-clk32 pulse per line (the vertical counter's clock enable)
- iivsync  input  1  active-low vsync from the vertical sync generator
- cfg_we  input  1  one-cycle write strobe
- cfg_res  input  2  resolution: 0=low, 1=med, 2=mono, 3=reserved (treated as mono)
- cfg_ntsc  input  1  1=60 Hz colour timing
- cfg_ilace  input  1  1=interlace enabled
- mde1  output  1  committed mono mode (cfg_res[1])
- mde1b  output  1  always ~mde1
- ntsc  output  1  committed ntsc
- interlace  output  1  committed interlace
- field  output  1  current interlace field
- busy  output  1  a pending config awaits commit
- vs_start  output  1  one-cycle pulse on a detected vsync falling edge
- timeout  output  1  sticky: the last commit was forced by the watchdog

Behaviour:
- Reset (synchronous, highest priority):
  - mde1=0, mde1b=1, ntsc=0, interlace=0, field=0, busy=0, vs_start=0, timeout=0.
  - State IDLE, line counter 0, pending register 0, vsync sample register 1.
- Edge detect:
  - vs_q <= iivsync every cycle.
  - vs_fall = vs_q & ~iivsync (combinational).
  - vs_start is vs_fall registered, so it appears 1 cycle after the edge is sampled.
- States:
  - IDLE: busy=0. On cfg_we, capture {cfg_res[1], cfg_ntsc, cfg_ilace} into pending, clear timeout, clear line counter, go to PENDING.
  - PENDING: busy=1.
    - cfg_we overwrites pending (last write wins) and clears the line counter.
    - On vs_fall, go to COMMIT.
    - Else, on vertclk_en, the counter increments. When the counter equals TIMEOUT_LINES-1 and vertclk_en=1, set timeout=1 and go to COMMIT.
    - cfg_we in the same cycle as vertclk_en: the counter clears; the write takes priority.
  - COMMIT (exactly 1 cycle):
    - Load mde1, ntsc, interlace from pending; mde1b=~pending mono.
    - If the committed interlace=0, field <= 0.
    - Go to IDLE, or to PENDING if cfg_we is asserted this cycle. That write is captured and waits for the next vsync.
- Commit latency: outputs change 2 clk32 cycles after the cycle in which iivsync is first sampled low.
- Simultaneous cfg_we and vs_fall in PENDING: the new write overwrites pending before the commit. COMMIT applies the newest value.
- Field:
  - On every vs_fall, field toggles if the interlace currently committed (before any same-frame commit) is 1.
  - Otherwise field is held at 0.
- vs_start pulses on every vsync, regardless of state.
- The watchdog counts only in PENDING and saturates at the commit, so it never wraps.
- timeout clears only on the next cfg_we or on reset.
- cfg_res=3 is treated identically to 2.

Optional Feature:
- VMODE_FRAMECNT_EN defined:
  - Adds output frame_cnt [15:0], reset to 0.
  - Increments by 1 on each vs_fall and wraps from 0xFFFF to 0x0000.
  - Adds output commit_pulse, high for the COMMIT cycle.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Reset, then hold iivsync=1 → mde1=0, mde1b=1, ntsc=0, interlace=0, field=0, busy=0.
- Write cfg_res=2, cfg_ntsc=0, cfg_ilace=0 mid-frame; drop iivsync 50 lines later → busy=1 until the commit; mde1=1 and mde1b=0 two cycles after the fall; timeout=0.
- Write res=0 then res=2 before vsync → only mde1=1 is committed. Separately, a write coincident with COMMIT → the second value stays pending, busy=1, and commits at the following vsync.
- Commit cfg_ilace=1, then give 4 vsync falls → field sequence 0,1,0,1. Then commit ilace=0 → field=0 thereafter.
- Write config and never drop iivsync; give 600 vertclk_en pulses → commit after the 600th pulse, timeout=1. A later cfg_we clears timeout.
- With VMODE_FRAMECNT_EN defined, preset to 0xFFFE, give 3 vsync falls → frame_cnt=0xFFFF, 0x0000, 0x0001.
